// File: rtl/add_serial_pkg.sv
// Shared types for the round-robin bit-serial adder scheduler.
package add_serial_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADD  = 2'd1,
    DONE = 2'd2
  } state_e;

  // Index width for n items, never narrower than one bit.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/add_serial_core.sv
// Bit-serial adder datapath: operand shift registers, carry flop and LSB-first sum shifter.
// sum_o/carry_o give the sum word and carry as they will stand after the current step.
module add_serial_core
  import add_serial_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             load_i,
  input  logic             step_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic [WIDTH-1:0] sum_o,
  output logic             carry_o
);

  logic [WIDTH-1:0] a_q, b_q, out_q;
  logic             carry_q;
  logic             bit_sum;

  always_comb begin
    bit_sum = a_q[0] ^ b_q[0] ^ carry_q;
    sum_o   = {bit_sum, out_q[WIDTH-1:1]};
    carry_o = (a_q[0] & b_q[0]) | (a_q[0] & carry_q) | (b_q[0] & carry_q);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      a_q     <= '0;
      b_q     <= '0;
      out_q   <= '0;
      carry_q <= 1'b0;
    end else if (load_i) begin
      a_q     <= a_i;
      b_q     <= b_i;
      out_q   <= '0;
      carry_q <= 1'b0;
    end else if (step_i) begin
      a_q     <= a_q >> 1;
      b_q     <= b_q >> 1;
      out_q   <= sum_o;
      carry_q <= carry_o;
    end
  end

endmodule

// File: rtl/add_serial_sched.sv
// Round-robin scheduler sharing one bit-serial adder among NREQ requesters.
// Define ADD_SERIAL_SCHED_SAT_EN to saturate rsp_sum to all-ones on carry-out.
module add_serial_sched
  import add_serial_pkg::*;
#(
  parameter int unsigned NREQ  = 4,
  parameter int unsigned WIDTH = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NREQ-1:0]         req,
  input  logic [NREQ*WIDTH-1:0]   req_a,
  input  logic [NREQ*WIDTH-1:0]   req_b,
  output logic [NREQ-1:0]         gnt,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [$clog2(NREQ)-1:0] rsp_id,
  output logic [WIDTH-1:0]        rsp_sum,
  output logic                    rsp_carry,
  output logic                    busy
);

  localparam int unsigned IdW  = idx_width(NREQ);
  localparam int unsigned CntW = idx_width(WIDTH);

  state_e           state_q;
  logic [IdW-1:0]   last_q, cur_id_q, rsp_id_q, sel_id;
  logic [CntW-1:0]  count_q;
  logic             rsp_valid_q, rsp_carry_q, busy_q;
  logic [WIDTH-1:0] rsp_sum_q;
  logic             any_req, core_load, core_step, core_carry;
  logic [WIDTH-1:0] core_sum, sel_a, sel_b;
  int unsigned      idx;

  // Search starts one past the last winner so every requester gets a turn.
  always_comb begin
    any_req = 1'b0;
    sel_id  = '0;
    idx     = 0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      idx = (32'(last_q) + 32'd1 + k) % NREQ;
      if (!any_req && req[idx[IdW-1:0]]) begin
        any_req = 1'b1;
        sel_id  = idx[IdW-1:0];
      end
    end
  end

  always_comb begin
    gnt       = '0;
    core_load = (state_q == IDLE) && any_req;
    core_step = (state_q == ADD);
    sel_a     = req_a[sel_id*WIDTH +: WIDTH];
    sel_b     = req_b[sel_id*WIDTH +: WIDTH];
    if (core_load) gnt[sel_id] = 1'b1;
  end

  add_serial_core #(
    .WIDTH(WIDTH)
  ) u_core (
    .clk_i  (clk),
    .rst_i  (rst),
    .load_i (core_load),
    .step_i (core_step),
    .a_i    (sel_a),
    .b_i    (sel_b),
    .sum_o  (core_sum),
    .carry_o(core_carry)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      last_q      <= IdW'(NREQ - 1);
      cur_id_q    <= '0;
      count_q     <= '0;
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= '0;
      rsp_sum_q   <= '0;
      rsp_carry_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (any_req) begin
            state_q  <= ADD;
            last_q   <= sel_id;
            cur_id_q <= sel_id;
            count_q  <= '0;
            busy_q   <= 1'b1;
          end
        end
        ADD: begin
          if (count_q == CntW'(WIDTH - 1)) begin
            state_q     <= DONE;
            rsp_valid_q <= 1'b1;
            rsp_id_q    <= cur_id_q;
            rsp_carry_q <= core_carry;
`ifdef ADD_SERIAL_SCHED_SAT_EN
            rsp_sum_q   <= core_carry ? '1 : core_sum;
`else
            rsp_sum_q   <= core_sum;
`endif
          end else begin
            count_q <= count_q + 1'b1;
          end
        end
        DONE: begin
          if (rsp_ready) begin
            state_q     <= IDLE;
            rsp_valid_q <= 1'b0;
            busy_q      <= 1'b0;
          end
        end
        default: begin
          state_q     <= IDLE;
          rsp_valid_q <= 1'b0;
          busy_q      <= 1'b0;
        end
      endcase
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_id    = rsp_id_q;
  assign rsp_sum   = rsp_sum_q;
  assign rsp_carry = rsp_carry_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_add_serial_sched.sv
// Directed bench for add_serial_sched: arbitration order, latency, backpressure and reset abort.
module tb_add_serial_sched;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req;
  logic [31:0] req_a, req_b;
  logic [3:0]  gnt;
  logic        rsp_valid, rsp_ready, rsp_carry, busy;
  logic [1:0]  rsp_id;
  logic [7:0]  rsp_sum;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  add_serial_sched #(
    .NREQ (4),
    .WIDTH(8)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .req      (req),
    .req_a    (req_a),
    .req_b    (req_b),
    .gnt      (gnt),
    .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready),
    .rsp_id   (rsp_id),
    .rsp_sum  (rsp_sum),
    .rsp_carry(rsp_carry),
    .busy     (busy)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req = '0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic set_ops(input int id, input logic [7:0] a, input logic [7:0] b);
    req_a[id*8 +: 8] = a;
    req_b[id*8 +: 8] = b;
  endtask

  // Single request with rsp_ready high: grant now, result at T+9, idle at T+10.
  task automatic run_one(input int id, input logic [7:0] a, input logic [7:0] b,
                         input logic [7:0] es, input logic ec);
    logic [3:0] one;
    one     = '0;
    one[id] = 1'b1;
    set_ops(id, a, b);
    req = one;
    #1;
    check("gnt", 32'(gnt), 32'(one));
    tick();
    req = '0;
    #1;
    check("gnt_pulse", 32'(gnt), 32'd0);
    check("busy_add", 32'(busy), 32'd1);
    repeat (7) tick();
    check("valid_early", 32'(rsp_valid), 32'd0);
    tick();
    check("valid", 32'(rsp_valid), 32'd1);
    check("rsp_id", 32'(rsp_id), 32'(id));
    check("rsp_sum", 32'(rsp_sum), 32'(es));
    check("rsp_carry", 32'(rsp_carry), 32'(ec));
    tick();
    check("idle_busy", 32'(busy), 32'd0);
    check("idle_valid", 32'(rsp_valid), 32'd0);
    check("sum_held", 32'(rsp_sum), 32'(es));
  endtask

  // Hold req and record the first n grants; nibble i of exp_seq is the i-th expected gnt.
  task automatic grant_order(input logic [3:0] r, input int n, input logic [19:0] exp_seq);
    int cnt, cyc, last_cyc;
    cnt      = 0;
    cyc      = 0;
    last_cyc = 0;
    req      = r;
    #1;
    while (cnt < n && cyc < 100) begin
      if (gnt != '0) begin
        check("gnt_order", 32'(gnt), 32'(exp_seq[cnt*4 +: 4]));
        if (cnt > 0) check("gnt_gap", cyc - last_cyc, 10);
        last_cyc = cyc;
        cnt++;
      end
      tick();
      cyc++;
    end
    check("gnt_count", cnt, n);
    req = '0;
    cyc = 0;
    while (busy && cyc < 30) begin
      tick();
      cyc++;
    end
    check("drain", 32'(busy), 32'd0);
  endtask

  initial begin
    logic [7:0] ovf_sum;
`ifdef ADD_SERIAL_SCHED_SAT_EN
    ovf_sum = 8'hFF;
`else
    ovf_sum = 8'h00;
`endif
    req_a     = '0;
    req_b     = '0;
    rsp_ready = 1'b1;
    do_reset();
    check("rst_gnt", 32'(gnt), 32'd0);
    check("rst_valid", 32'(rsp_valid), 32'd0);
    check("rst_id", 32'(rsp_id), 32'd0);
    check("rst_sum", 32'(rsp_sum), 32'd0);
    check("rst_carry", 32'(rsp_carry), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);

    run_one(0, 8'h5A, 8'h3C, 8'h96, 1'b0);
    run_one(1, 8'hFF, 8'h01, ovf_sum, 1'b1);
    run_one(2, 8'hA5, 8'h5A, 8'hFF, 1'b0);

    do_reset();
    grant_order(4'b0101, 4, {4'b0000, 4'b0100, 4'b0001, 4'b0100, 4'b0001});
    do_reset();
    grant_order(4'b1111, 5, {4'b0001, 4'b1000, 4'b0100, 4'b0010, 4'b0001});

    // Backpressure: result must hold in DONE and no grant may issue.
    do_reset();
    rsp_ready = 1'b0;
    set_ops(2, 8'h10, 8'h20);
    req = 4'b0100;
    #1;
    check("bp_gnt", 32'(gnt), 32'h4);
    tick();
    req = '0;
    repeat (8) tick();
    req = 4'b1111;
    #1;
    for (int i = 0; i < 5; i++) begin
      check("bp_valid", 32'(rsp_valid), 32'd1);
      check("bp_sum", 32'(rsp_sum), 32'h30);
      check("bp_id", 32'(rsp_id), 32'd2);
      check("bp_busy", 32'(busy), 32'd1);
      check("bp_nognt", 32'(gnt), 32'd0);
      tick();
    end
    req       = '0;
    rsp_ready = 1'b1;
    tick();
    check("bp_rel_busy", 32'(busy), 32'd0);
    check("bp_rel_valid", 32'(rsp_valid), 32'd0);

    // Reset in the third ADD cycle aborts the add.
    do_reset();
    check("rst2_sum", 32'(rsp_sum), 32'd0);
    set_ops(0, 8'h11, 8'h22);
    req = 4'b0001;
    #1;
    check("ab_gnt", 32'(gnt), 32'h1);
    tick();
    req = '0;
    tick();
    tick();
    rst = 1'b1;
    tick();
    check("ab_busy", 32'(busy), 32'd0);
    check("ab_valid", 32'(rsp_valid), 32'd0);
    check("ab_sum", 32'(rsp_sum), 32'd0);
    rst = 1'b0;
    set_ops(3, 8'h07, 8'h08);
    req = 4'b1000;
    #1;
    check("ab_gnt3", 32'(gnt), 32'h8);
    tick();
    req = '0;
    repeat (7) tick();
    check("ab_valid_early", 32'(rsp_valid), 32'd0);
    tick();
    check("ab_valid3", 32'(rsp_valid), 32'd1);
    check("ab_id3", 32'(rsp_id), 32'd3);
    check("ab_sum3", 32'(rsp_sum), 32'h0F);
    check("ab_carry3", 32'(rsp_carry), 32'd0);
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/add_serial_sched.md
# add_serial_sched

Shared-resource scheduler for the bit-serial adder datapath. It accepts add requests from `NREQ` independent requesters and arbitrates between them round-robin. It runs the granted operand pair through one shared serial add, LSB first, and returns the sum tagged with the requester index over a valid/ready response channel. Only one add is in flight at a time.

## Interface
Parameters:
- `NREQ`, 4: number of requesters, ≥2.
- `WIDTH`, 8: operand and sum width in bits, ≥2.

Ports:
- `clk`, input, 1: single clock, rising edge.
- `rst`, input, 1: reset. Synchronous and active-high.
- `req`, input, `NREQ`: per-requester request. Each requester holds it high until its `gnt` bit is seen.
- `req_a`, input, `NREQ*WIDTH`: operand A. Requester i occupies `[i*WIDTH +: WIDTH]`.
- `req_b`, input, `NREQ*WIDTH`: operand B, same packing as `req_a`.
- `gnt`, output, `NREQ`: one-hot, 1-cycle pulse. Operands of the granted requester are captured on this edge.
- `rsp_valid`, output, 1: result available.
- `rsp_ready`, input, 1: consumer accepts the result.
- `rsp_id`, output, `$clog2(NREQ)`: index of the requester that owns the result.
- `rsp_sum`, output, `WIDTH`: sum.
- `rsp_carry`, output, 1: final carry-out.
- `busy`, output, 1: high when the state is not IDLE.

## Operation
- State register is 2 bits: IDLE=0, ADD=1, DONE=2. Encoding 3 is illegal and goes to IDLE on the next edge.
- **IDLE**
  - If any `req` bit is high, select one requester round-robin and assert its `gnt` bit (combinational in IDLE only).
  - Load `a_reg`/`b_reg` with that requester's operands. Clear `carry`, `out` and `count`. Record the index in `cur_id`. Go to ADD.
  - If no `req` bit is high, stay in IDLE.
- **Round-robin rule:** search starts at `(last+1) mod NREQ`. `last` updates to the granted index on the grant edge. After reset, `last = NREQ-1`, so requester 0 has top priority.
- **ADD**, one bit per cycle:
  - `sum = a_reg[0]^b_reg[0]^carry`.
  - `out <= {sum, out[WIDTH-1:1]}`.
  - `carry <=` majority of `a_reg[0]`, `b_reg[0]`, `carry`.
  - `a_reg`/`b_reg` shift right by 1. `count` increments.
  - When `count == WIDTH-1`, go to DONE. `count` is `$clog2(WIDTH)` bits and never wraps inside ADD.
- **DONE**
  - `rsp_valid=1`. `rsp_id=cur_id`, `rsp_sum` and `rsp_carry` are held stable.
  - When `rsp_ready` is high, go to IDLE. No grant is issued in DONE.
- Outputs outside DONE: `rsp_valid=0`. `rsp_sum`, `rsp_id` and `rsp_carry` keep their last values (0 after reset).
- `req` changes while busy are ignored. A requester still asserting `req` in IDLE is arbitrated normally, including a requester that was just served.
- Reset values: state=IDLE, `gnt=0`, `rsp_valid=0`, `rsp_id=0`, `rsp_sum=0`, `rsp_carry=0`, `busy=0`, `last=NREQ-1`.
- Reset in any state, including mid-ADD or DONE with `rsp_valid` high, aborts the operation and discards the result. Reset has priority over every other event.

## Timing
- Grant in cycle T. ADD occupies T+1 through T+WIDTH. `rsp_valid` rises in T+WIDTH+1.
- `rsp_ready` already high when `rsp_valid` rises: handshake completes that cycle and the state is IDLE at T+WIDTH+2.
- Earliest next grant is T+WIDTH+2, so peak throughput is one add per WIDTH+2 cycles.
- `gnt` depends combinationally on `req` and state. All other outputs are registered.

## Configuration
- `ADD_SERIAL_SCHED_SAT_EN` defined: when the final carry is 1, `rsp_sum` is forced to all-ones (saturating add). `rsp_carry` still reports 1.
- Not defined: `rsp_sum` is the wrapped sum modulo 2^WIDTH.

## Structure
- Package `add_serial_pkg` holds:
  - the state typedef (`IDLE`, `ADD`, `DONE`, 2 bits);
  - a `$clog2`-based index-width helper constant.
- Sub-module `add_serial_core` holds the datapath: `a_reg`, `b_reg`, `carry` and the `out` shift register, with `load`/`step` controls and `sum_o`/`carry_o` outputs.
- The round-robin arbiter, FSM and response register stay in the top level.

## Test plan
- After reset, `req=4'b0001`, a=0x5A, b=0x3C → `gnt=0001` for 1 cycle. Nine cycles later `rsp_valid=1`, `rsp_id=0`, `rsp_sum=0x96`, `rsp_carry=0`.
- Requester 1: a=0xFF, b=0x01 → `rsp_carry=1`. `rsp_sum=0x00` without the macro, 0xFF with `ADD_SERIAL_SCHED_SAT_EN`.
- `req=4'b0101` held continuously with `rsp_ready=1` → grants in order 0, 2, 0, 2. Consecutive grants are exactly 10 cycles apart.
- `req=4'b1111` held → grant order 0, 1, 2, 3, 0.
- Hold `rsp_ready=0` for 5 cycles in DONE → `rsp_valid`, `rsp_sum` and `rsp_id` stay stable, `busy=1`, no `gnt` pulse. Release → IDLE on the next cycle.
- Assert `rst` in the 3rd ADD cycle → next cycle state=IDLE, `busy=0`, `rsp_valid=0`. A subsequent `req=4'b1000` is granted, and the earlier operation's result never appears.
